// File: rtl/pc_pkg.sv
// Shared types and constants for the RV32I fetch PC sequencer.
//   redir_kind_t : encoding of the redirect kind coming from execute
//   pc_state_t   : BOOT / RUN / HALTED encoding presented on the state port
//   PC_STEP      : sequential fetch increment in bytes
package pc_pkg;

    typedef enum logic [1:0] {
        BRANCH = 2'b00,
        JAL    = 2'b01,
        JALR   = 2'b10,
        RSVD   = 2'b11
    } redir_kind_t;

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } pc_state_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target calculator (purely combinational).
//   kind       in  2      redirect kind (see pc_pkg::redir_kind_t)
//   base       in  WIDTH  PC of the redirecting instruction
//   imm        in  WIDTH  sign-extended immediate
//   rs1        in  WIDTH  rs1 value, used by jalr only
//   target     out WIDTH  raw target (jalr has bit 0 cleared)
//   misaligned out 1      target is not word aligned (bit 1 set)
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       kind,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] rs1,
    output logic [WIDTH-1:0] target,
    output logic             misaligned
);

    logic [WIDTH-1:0] rel_sum;
    logic [WIDTH-1:0] ind_sum;

    always_comb begin
        rel_sum = base + imm;
        ind_sum = rs1 + imm;
        // Reserved kind falls back to PC-relative like branch/jal.
        if (kind == JALR) begin
            target = {ind_sum[WIDTH-1:1], 1'b0};
        end else begin
            target = rel_sum;
        end
        // Bit 0 is always clear for jalr and irrelevant for 4-byte fetch;
        // only bit 1 marks a word-misaligned target.
        misaligned = target[1];
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage program counter sequencer.
// Holds the fetch PC, advances it by PC_STEP per running unstalled cycle and
// applies trap / execute redirects, with a BOOT/RUN/HALTED state machine
// gating fetch.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : a redirect target with bit 1 set loads TRAP_VECTOR, pulses
//               misalign_exc and records the target in misalign_addr.
//   undefined : target bits [1:0] are forced to zero; misalign outputs tie 0.
//
// Ports:
//   clk, rst (asynchronous, active-high)
//   stall, halt, resume                 control inputs
//   redir_valid/kind/base/imm/rs1       execute redirect request
//   trap_valid, trap_pc                 external trap request
//   pc, pc_plus4                        registered fetch PC and PC+4
//   fetch_valid                         (state==RUN) & ~stall, combinational
//   flush                               one-cycle pulse after accepted redirect/trap
//   state                               00 BOOT, 01 RUN, 10 HALTED
//   misalign_exc, misalign_addr         alignment trap report
module fetch_pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0004)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             redir_valid,
    input  logic [1:0]       redir_kind,
    input  logic [WIDTH-1:0] redir_base,
    input  logic [WIDTH-1:0] redir_imm,
    input  logic [WIDTH-1:0] redir_rs1,
    input  logic             trap_valid,
    input  logic [WIDTH-1:0] trap_pc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_valid,
    output logic             flush,
    output logic [1:0]       state,
    output logic             misalign_exc,
    output logic [WIDTH-1:0] misalign_addr
);

    localparam logic [1:0] ST_BOOT   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] pc_plus4_reg;
    logic [1:0]       state_reg, state_next;
    logic             flush_reg;

    logic [WIDTH-1:0] target_raw;
    logic             target_misaligned;
    logic [WIDTH-1:0] redir_load;
    logic             trap_taken;

    pc_target_calc #(.WIDTH(WIDTH)) u_target (
        .kind       (redir_kind),
        .base       (redir_base),
        .imm        (redir_imm),
        .rs1        (redir_rs1),
        .target     (target_raw),
        .misaligned (target_misaligned)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic             misalign_exc_reg;
    logic [WIDTH-1:0] misalign_addr_reg;
    logic             align_fault;

    // External traps bypass the check; only a surviving redirect is tested.
    assign align_fault = redir_valid & ~trap_valid & target_misaligned;
    assign redir_load  = target_misaligned ? TRAP_VECTOR : target_raw;
    assign trap_taken  = trap_valid | align_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_exc_reg  <= 1'b0;
            misalign_addr_reg <= '0;
        end else begin
            misalign_exc_reg <= align_fault;
            if (align_fault) begin
                misalign_addr_reg <= target_raw;
            end
        end
    end

    assign misalign_exc  = misalign_exc_reg;
    assign misalign_addr = misalign_addr_reg;
`else
    logic unused_align;

    assign redir_load    = {target_raw[WIDTH-1:2], 2'b00};
    assign trap_taken    = trap_valid;
    assign misalign_exc  = 1'b0;
    assign misalign_addr = '0;
    assign unused_align  = ^{target_misaligned, target_raw[1:0], TRAP_VECTOR};
`endif

    // Next PC: trap, then redirect, then hold, then sequential step.
    always_comb begin
        pc_next = pc_reg;
        if (trap_valid) begin
            pc_next = trap_pc;
        end else if (redir_valid) begin
            pc_next = redir_load;
        end else if (stall || (state_reg != ST_RUN)) begin
            pc_next = pc_reg;
        end else begin
            pc_next = pc_reg + STEP;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BOOT:   state_next = halt ? ST_HALTED : ST_RUN;
            ST_RUN:    state_next = (halt && !trap_taken) ? ST_HALTED : ST_RUN;
            ST_HALTED: state_next = (resume || trap_valid) ? ST_RUN : ST_HALTED;
            default:   state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= RESET_VECTOR;
            pc_plus4_reg <= RESET_VECTOR + STEP;
            state_reg    <= ST_BOOT;
            flush_reg    <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            // Registered alongside pc so pc_plus4 is glitch-free.
            pc_plus4_reg <= pc_next + STEP;
            state_reg    <= state_next;
            flush_reg    <= trap_valid | redir_valid;
        end
    end

    assign pc          = pc_reg;
    assign pc_plus4    = pc_plus4_reg;
    assign state       = state_reg;
    assign flush       = flush_reg;
    assign fetch_valid = (state_reg == ST_RUN) & ~stall;

endmodule

// File: doc/fetch_pc_sequencer.md
# fetch_pc_sequencer

Parametrised program-counter sequencer for the RV32I fetch stage. It holds the fetch PC and advances it by 4 each cycle. It accepts PC-relative and register-indirect redirects from execute, plus trap redirects, and resolves them against stall and halt. A small BOOT/RUN/HALTED state machine gates fetch. An optional alignment checker converts misaligned targets into a trap.

## Interface
Parameters:
- WIDTH, 32, address/data width in bits (≥ 8)
- RESET_VECTOR, 0, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0004, PC loaded on a misalignment trap (used only with PC_ALIGN_CHECK_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold PC; fetch_valid deasserted
- halt  in  1  request entry to HALTED
- resume  in  1  leave HALTED
- redir_valid  in  1  redirect request from execute
- redir_kind  in  2  00 branch, 01 jal, 10 jalr, 11 reserved (treated as PC-relative)
- redir_base  in  WIDTH  PC of the redirecting instruction
- redir_imm  in  WIDTH  sign-extended immediate
- redir_rs1  in  WIDTH  rs1 value (jalr only)
- trap_valid  in  1  external trap request
- trap_pc  in  WIDTH  trap handler address
- pc  out  WIDTH  current fetch PC (registered)
- pc_plus4  out  WIDTH  pc + 4, modulo 2^WIDTH
- fetch_valid  out  1  fetch at pc is valid this cycle
- flush  out  1  registered one-cycle pulse after any accepted redirect or trap
- state  out  2  00 BOOT, 01 RUN, 10 HALTED
- misalign_exc  out  1  registered one-cycle pulse (PC_ALIGN_CHECK_EN only; else tied 0)
- misalign_addr  out  WIDTH  last offending target (PC_ALIGN_CHECK_EN only; else tied 0)

## Operation
- Targets:
  - PC-relative (kinds 00/01/11): base + imm, modulo 2^WIDTH.
  - jalr (10): (rs1 + imm) with bit 0 cleared.
- Next-PC priority, highest first:
  1. rst
  2. trap_valid → trap_pc
  3. redir_valid → target
  4. stall or state≠RUN → hold
  5. pc_plus4
- Stall never blocks a redirect or trap. The redirect is applied, and fetch_valid stays low while stall is high.
- FSM:
  - BOOT→RUN after one cycle; BOOT→HALTED instead if halt is high.
  - RUN→HALTED on halt, unless a trap is accepted in the same cycle.
  - HALTED→RUN on resume or trap_valid.
  - A redirect in HALTED updates pc but keeps the state HALTED.
- fetch_valid = (state==RUN) & ~stall. This is the only combinational output.
- flush is set at the clock edge where a redirect or trap updates pc.
- Reset values: pc=RESET_VECTOR, pc_plus4=RESET_VECTOR+4, state=BOOT, fetch_valid=0, flush=0, misalign_exc=0, misalign_addr=0.

## Timing
- Redirect or trap presented in cycle n: pc = target and flush=1 in cycle n+1. flush clears in n+2 unless re-triggered.
- Sequential advance: one pc increment per non-stalled RUN cycle. Wrap from 2^WIDTH−4 to 0 without error.
- Reset asserted mid-redirect discards the redirect; the reset values hold until the first edge after rst falls.
- trap_valid and redir_valid in the same cycle: the trap wins; the redirect is dropped, with no retry.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - A redirect target with bit 1 set is not taken. pc loads TRAP_VECTOR instead.
  - misalign_exc pulses in the cycle after; misalign_addr captures the target; flush=1.
  - An external trap_valid is never checked.
- Undefined:
  - Target bits [1:0] are forced to 0 before loading.
  - misalign_exc and misalign_addr are tied 0.

## Structure
- Package pc_pkg holds:
  - redir_kind_t enum (BRANCH, JAL, JALR, RSVD)
  - pc_state_t enum (BOOT, RUN, HALTED)
  - constant PC_STEP = 4
- Sub-module pc_target_calc is purely combinational. It produces the target and the misaligned flag from kind/base/imm/rs1.
- The top module holds the PC register, the FSM and the flags.

## Test plan
- Reset, then release; no other inputs → cycle 1 BOOT with fetch_valid=0, pc=0; then RUN with pc 0,4,8,12 on successive cycles.
- pc=0x100, branch with redir_base=0xF8, imm=0x20 → next pc=0x118, flush=1 for one cycle.
- jalr with rs1=0x2001, imm=0x10 → pc=0x2010 (bit 0 cleared); plus trap_valid (trap_pc=0x80) raised in the same cycle as a redirect → pc=0x80.
- stall held 3 cycles at pc=0x40 → pc stays 0x40 with fetch_valid=0; a branch during the stall still loads the target.
- halt in RUN → HALTED, pc frozen; resume → RUN, and increments continue from the frozen pc.
- With PC_ALIGN_CHECK_EN, jal target 0x302 → pc=TRAP_VECTOR, misalign_exc pulse, misalign_addr=0x302. Without the macro, the same stimulus → pc=0x300.
